// File: rtl/engine_gear_ctrl.sv
// Engine/gearbox sequencer for the drag-racing game: throttle-driven RPM with
// rev limiter, timed gear changes with RPM rescaling, and a staged pre-race state.
module engine_gear_ctrl #(
  parameter int RPM_IDLE    = 1000,
  parameter int RPM_MAX     = 9000,
  parameter int RPM_DECAY   = 40,
  parameter int STEP0       = 120,
  parameter int STEP1       = 80,
  parameter int STEP2       = 50,
  parameter int STEP3       = 30,
  parameter int SHIFT_TICKS = 20
) (
  input  logic        clk100Hz,
  input  logic        rst,
  input  logic        throttle,
  input  logic        shift_up,
  input  logic        shift_down,
  input  logic        race_go,
  input  logic        reset_status,
  output logic [13:0] rpm,
  output logic [1:0]  gear,
  output logic        shifting,
  output logic        overrev
);

  localparam int CW = (SHIFT_TICKS > 1) ? $clog2(SHIFT_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SHIFT_TICKS - 1);

  localparam logic [13:0] IDLE14  = 14'(RPM_IDLE);
  localparam logic [13:0] MAX14   = 14'(RPM_MAX);
  localparam logic [14:0] MAX15   = 15'(RPM_MAX);
  localparam logic [13:0] DECAY14 = 14'(RPM_DECAY);
  localparam logic [14:0] FLOOR15 = 15'(RPM_IDLE + RPM_DECAY);
  localparam logic [14:0] S0      = 15'(STEP0);
  localparam logic [14:0] S1      = 15'(STEP1);
  localparam logic [14:0] S2      = 15'(STEP2);
  localparam logic [14:0] S3      = 15'(STEP3);

  typedef enum logic [1:0] {STAGED, RUN, SHIFT} state_t;

  state_t        state, state_nx;
  logic [13:0]   rpm_nx;
  logic [1:0]    gear_nx;
  logic          ov_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          up_d, down_d, go_d;

  logic          up_ev, down_ev, go_ev;
  logic          up_ok, down_ok;
  logic [14:0]   rpm15, step, sum, dnv;
  logic [13:0]   upv, rule_rpm;
  logic          rule_ov;

  assign up_ev   = shift_up & ~up_d;
  assign down_ev = shift_down & ~down_d;
  assign go_ev   = race_go & ~go_d;

  assign rpm15 = {1'b0, rpm};
  assign sum   = rpm15 + step;
  assign dnv   = rpm15 + (rpm15 >> 1);
  assign upv   = rpm - (rpm >> 2);

  assign up_ok   = up_ev & ~down_ev & (gear != 2'd3);
  assign down_ok = down_ev & ~up_ev & (gear != 2'd0) & (dnv <= MAX15);

  assign shifting = (state == SHIFT);

  always_ff @(posedge clk100Hz or negedge rst) begin
    if (!rst) begin
      state   <= STAGED;
      rpm     <= IDLE14;
      gear    <= 2'd0;
      overrev <= 1'b0;
      cnt     <= '0;
      up_d    <= 1'b0;
      down_d  <= 1'b0;
      go_d    <= 1'b0;
    end else begin
      state   <= state_nx;
      rpm     <= rpm_nx;
      gear    <= gear_nx;
      overrev <= ov_nx;
      cnt     <= cnt_nx;
      up_d    <= shift_up;
      down_d  <= shift_down;
      go_d    <= race_go;
    end
  end

  // Per-tick RPM rule: accelerate with limiter, or decay to the idle floor.
  always_comb begin
    step     = S0;
    rule_rpm = rpm;
    rule_ov  = 1'b0;
    case (gear)
      2'd0: step = S0;
      2'd1: step = S1;
      2'd2: step = S2;
      default: step = S3;
    endcase
    if (throttle) begin
      if (sum >= MAX15) begin
        rule_rpm = MAX14;
        rule_ov  = 1'b1;
      end else begin
        rule_rpm = sum[13:0];
      end
    end else if (rpm15 >= FLOOR15) begin
      rule_rpm = rpm - DECAY14;
    end else begin
      rule_rpm = IDLE14;
    end
  end

  always_comb begin
    state_nx = state;
    rpm_nx   = rpm;
    gear_nx  = gear;
    ov_nx    = overrev;
    cnt_nx   = cnt;
    if (reset_status) begin
      state_nx = STAGED;
      rpm_nx   = IDLE14;
      gear_nx  = 2'd0;
      ov_nx    = 1'b0;
      cnt_nx   = '0;
    end else begin
      case (state)
        STAGED: begin
          gear_nx = 2'd0;
          rpm_nx  = rule_rpm;
          ov_nx   = rule_ov;
          if (go_ev) state_nx = RUN;
        end
        RUN: begin
          if (up_ok) begin
            state_nx = SHIFT;
            gear_nx  = gear + 2'd1;
            rpm_nx   = (upv < IDLE14) ? IDLE14 : upv;
            ov_nx    = 1'b0;
            cnt_nx   = CNT_LOAD;
          end else if (down_ok) begin
            state_nx = SHIFT;
            gear_nx  = gear - 2'd1;
            rpm_nx   = dnv[13:0];
            ov_nx    = 1'b0;
            cnt_nx   = CNT_LOAD;
          end else begin
            rpm_nx = rule_rpm;
            ov_nx  = rule_ov;
          end
        end
        SHIFT: begin
          if (cnt == '0) state_nx = RUN;
          else cnt_nx = cnt - 1'b1;
        end
        default: state_nx = STAGED;
      endcase
    end
  end

endmodule

// File: tb/tb_engine_gear_ctrl.sv
// Directed, table-driven bench for engine_gear_ctrl with hand-computed RPM/gear
// trajectories through staging, rev limiting, shifts and race reset.
module tb_engine_gear_ctrl;

  logic        clk100Hz = 1'b0;
  logic        rst;
  logic        throttle, shift_up, shift_down, race_go, reset_status;
  logic [13:0] rpm;
  logic [1:0]  gear;
  logic        shifting, overrev;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic thr, up, dn, go, rs;
    int   rpm, gear;
    logic sh, ov;
  } vec_t;

  vec_t tbl[$];

  engine_gear_ctrl dut (
    .clk100Hz     (clk100Hz),
    .rst          (rst),
    .throttle     (throttle),
    .shift_up     (shift_up),
    .shift_down   (shift_down),
    .race_go      (race_go),
    .reset_status (reset_status),
    .rpm          (rpm),
    .gear         (gear),
    .shifting     (shifting),
    .overrev      (overrev)
  );

  always #5 clk100Hz = ~clk100Hz;

  function automatic void add(input logic thr, up, dn, go, rs,
                              input int r, g, input logic sh, ov);
    vec_t v;
    v.thr = thr; v.up = up; v.dn = dn; v.go = go; v.rs = rs;
    v.rpm = r; v.gear = g; v.sh = sh; v.ov = ov;
    tbl.push_back(v);
  endfunction

  task automatic check(input string nm, input int idx, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s row %0d: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input int r, g, input logic sh, ov);
    check("rpm", idx, int'(rpm), r);
    check("gear", idx, int'(gear), g);
    check("shifting", idx, int'(shifting), int'(sh));
    check("overrev", idx, int'(overrev), int'(ov));
  endtask

  task automatic shift_rows(input logic thr, input int r, g);
    for (int s = 2; s <= 20; s++) add(thr, 0, 0, 0, 0, r, g, 1, 0);
    add(thr, 0, 0, 0, 0, r, g, 0, 0);
  endtask

  task automatic build_table();
    for (int k = 1; k <= 5; k++) add(0, 0, 0, 0, 0, 1000, 0, 0, 0);
    for (int k = 1; k <= 10; k++) add(1, 0, 0, 0, 0, 1000 + 120 * k, 0, 0, 0);
    for (int k = 1; k <= 40; k++)
      add(0, 0, 0, 0, 0, (2200 - 40 * k < 1000) ? 1000 : 2200 - 40 * k, 0, 0, 0);
    // Upshift attempt while staged has no effect
    add(0, 1, 0, 0, 0, 1000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1000, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1000, 0, 0, 0);
    for (int k = 1; k <= 60; k++) add(1, 0, 0, 0, 0, 1000 + 120 * k, 0, 0, 0);
    for (int k = 1; k <= 5; k++) add(0, 0, 0, 0, 0, 8200 - 40 * k, 0, 0, 0);
    for (int k = 1; k <= 8; k++) add(1, 0, 0, 0, 0, 8000 + 120 * k, 0, 0, 0);
    add(1, 0, 0, 0, 0, 9000, 0, 0, 1);
    add(1, 0, 0, 0, 0, 9000, 0, 0, 1);
    add(0, 0, 0, 0, 0, 8960, 0, 0, 0);
    for (int k = 1; k <= 24; k++) add(0, 0, 0, 0, 0, 8960 - 40 * k, 0, 0, 0);
    // Upshift at 8000 with throttle held; second up edge mid-shift, held past the end
    add(1, 1, 0, 0, 0, 6000, 1, 1, 0);
    for (int s = 2; s <= 20; s++) add(1, s >= 5, 0, 0, 0, 6000, 1, 1, 0);
    add(1, 1, 0, 0, 0, 6000, 1, 0, 0);
    add(1, 1, 0, 0, 0, 6080, 1, 0, 0);
    add(1, 0, 0, 0, 0, 6160, 1, 0, 0);
    add(0, 1, 0, 0, 0, 4620, 2, 1, 0);
    shift_rows(0, 4620, 2);
    for (int k = 1; k <= 50; k++) add(1, 0, 0, 0, 0, 4620 + 50 * k, 2, 0, 0);
    for (int k = 1; k <= 3; k++) add(0, 0, 0, 0, 0, 7120 - 40 * k, 2, 0, 0);
    // Downshift at 7000 rejected (10500 > 9000), then simultaneous edges ignored
    add(0, 0, 1, 0, 0, 6960, 2, 0, 0);
    add(0, 0, 0, 0, 0, 6920, 2, 0, 0);
    add(0, 1, 1, 0, 0, 6880, 2, 0, 0);
    add(0, 0, 0, 0, 0, 6840, 2, 0, 0);
    for (int k = 1; k <= 71; k++) add(0, 0, 0, 0, 0, 6840 - 40 * k, 2, 0, 0);
    add(0, 0, 1, 0, 0, 6000, 1, 1, 0);
    shift_rows(0, 6000, 1);
    add(0, 1, 0, 0, 0, 4500, 2, 1, 0);
    shift_rows(0, 4500, 2);
    add(0, 1, 0, 0, 0, 3375, 3, 1, 0);
    for (int s = 2; s <= 4; s++) add(0, 0, 0, 0, 0, 3375, 3, 1, 0);
    // Race reset mid-shift, then a new race start and an upshift floored at idle
    add(0, 0, 0, 0, 1, 1000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1000, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1000, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1000, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1000, 1, 1, 0);
  endtask

  task automatic apply_stimulus(input vec_t v);
    throttle     = v.thr;
    shift_up     = v.up;
    shift_down   = v.dn;
    race_go      = v.go;
    reset_status = v.rs;
    @(posedge clk100Hz);
    #1;
  endtask

  initial begin
    rst          = 1'b0;
    throttle     = 1'b0;
    shift_up     = 1'b0;
    shift_down   = 1'b0;
    race_go      = 1'b0;
    reset_status = 1'b0;
    build_table();
    repeat (3) @(posedge clk100Hz);
    #1;
    check_outputs(-1, 1000, 0, 0, 0);
    @(negedge clk100Hz);
    rst = 1'b1;

    foreach (tbl[i]) begin
      apply_stimulus(tbl[i]);
      check_outputs(i, tbl[i].rpm, tbl[i].gear, tbl[i].sh, tbl[i].ov);
    end

    // Asynchronous reset in the middle of a shift clears everything at once
    #2;
    rst = 1'b0;
    #1;
    check_outputs(-2, 1000, 0, 0, 0);
    @(negedge clk100Hz);
    rst = 1'b1;
    throttle = 1'b1;
    @(posedge clk100Hz);
    #1;
    check_outputs(-3, 1120, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/engine_gear_ctrl.md
# engine_gear_ctrl

Sequencer for the engine/gearbox model of the Drag-Racing game. It runs at the 100 Hz game tick and owns the `rpm` and `gear` values that feed the velocity/position datapath. From the player's throttle and shift buttons it produces engine speed with a rev limiter, timed gear changes and RPM rescaling on each shift. It also forces a clean staged state between races.

## Interface
Parameters:
- `RPM_IDLE`, 1000: RPM floor and the post-reset value.
- `RPM_MAX`, 9000: rev limiter ceiling. Must be below 16384.
- `RPM_DECAY`, 40: RPM lost per tick with throttle released.
- `STEP0`/`STEP1`/`STEP2`/`STEP3`, 120/80/50/30: RPM gained per tick with throttle held, in gear 0/1/2/3.
- `SHIFT_TICKS`, 20: number of ticks spent in SHIFT (0.2 s). Must be at least 1.

Ports:
- `clk100Hz`, in, 1: game tick clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `throttle`, in, 1: level signal; 1 means throttle held.
- `shift_up`, in, 1: level signal; only its rising edge acts.
- `shift_down`, in, 1: level signal; only its rising edge acts.
- `race_go`, in, 1: level signal; its rising edge starts the race.
- `reset_status`, in, 1: synchronous race reset.
- `rpm`, out, 14: engine speed, registered.
- `gear`, out, 2: 0 to 3, registered.
- `shifting`, out, 1: high while in SHIFT.
- `overrev`, out, 1: high while RPM is held at `RPM_MAX` by the limiter.

## Operation
- States: STAGED, RUN, SHIFT.
- Edge detect: `shift_up`, `shift_down` and `race_go` each have a delay register. An event is `in & ~in_d`.
- Priority, highest first: `rst`, then `reset_status`, then the state logic.
- `reset_status`=1 forces:
  - state STAGED, `rpm`=`RPM_IDLE`, `gear`=0, shift counter cleared, `overrev`=0.
  - Edge detect registers still sample their inputs.
- RPM update rule (STAGED and RUN only):
  - Throttle held: `rpm` + STEP[gear], computed in 15 bits. If the sum is at least `RPM_MAX`, `rpm`=`RPM_MAX` and `overrev`=1. Otherwise `rpm`=sum and `overrev`=0.
  - Throttle released: `rpm` − `RPM_DECAY`, floored at `RPM_IDLE`. `overrev`=0.
- STAGED:
  - `gear` is held at 0 and the RPM rule applies (free revving on the line).
  - Shift events are ignored.
  - A `race_go` edge moves to RUN on the next tick.
- RUN:
  - The RPM rule applies.
  - An accepted shift moves to SHIFT. The acceptance tick itself does not apply the RPM rule.
- Upshift is accepted when there is a `shift_up` edge, no `shift_down` edge, and `gear`<3:
  - `gear`+1.
  - `rpm` = `rpm` − (`rpm`>>2), floored at `RPM_IDLE`.
- Downshift is accepted when there is a `shift_down` edge, no `shift_up` edge, and `gear`>0:
  - Candidate value v = `rpm` + (`rpm`>>1), computed in 15 bits.
  - If v > `RPM_MAX`, the downshift is rejected: no state change, and the RPM rule applies as normal.
  - Otherwise `gear`−1 and `rpm`=v.
- Invalid requests are ignored and not queued:
  - Simultaneous up and down edges.
  - Upshift in gear 3.
  - Downshift in gear 0.
- On accepting a shift: `overrev`=0 and the shift counter is loaded with `SHIFT_TICKS`−1.
- SHIFT:
  - `rpm` and `gear` are frozen.
  - Throttle and all shift edges are ignored and dropped.
  - The counter decrements each tick. When it is 0, the next state is RUN.
- `shifting` = (state==SHIFT), taken from the state register.

## Timing
- Reset values: `rpm`=`RPM_IDLE`, `gear`=0, `shifting`=0, `overrev`=0, state STAGED, edge delay registers=0.
- All outputs are registered and change only on `clk100Hz` edges, except during asynchronous reset.
- Input-to-output latency is 1 tick. A `shift_up` edge sampled at tick N gives new `gear`/`rpm` and `shifting`=1 at N+1.
- SHIFT lasts exactly `SHIFT_TICKS` ticks: `shifting` is high for `SHIFT_TICKS` consecutive ticks. The RPM rule resumes on the tick after `shifting` falls.
- A button held high through the end of SHIFT does not retrigger; a new rising edge is required.
- `reset_status` in mid-SHIFT takes effect at the next tick: `shifting`=0, `gear`=0, `rpm`=`RPM_IDLE`.
- `rst` asserted at any time clears the block immediately. Release is synchronous to the next edge of the top-level reset synchroniser.
- The `rpm` output never leaves the range [`RPM_IDLE`, `RPM_MAX`].

## Test plan
- Reset, then 5 ticks idle: `rpm`=1000, `gear`=0, `shifting`=0, `overrev`=0 throughout.
- STAGED, throttle held 10 ticks: `rpm`=2200. Release for 40 ticks: `rpm` decays to a floor of 1000. A `shift_up` edge in STAGED leaves `gear`=0.
- RUN, gear 0, throttle held from 8000: after 9 ticks `rpm`=9000 and `overrev`=1. Releasing the throttle clears `overrev` on the next tick and gives `rpm`=8960.
- RUN at `rpm`=8000, gear 0, `shift_up` pulse:
  - Next tick: `gear`=1, `rpm`=6000, `shifting`=1.
  - `shifting` stays high for 20 ticks with throttle held and `rpm` stays at 6000.
  - On the tick after, `rpm`=6080.
  - A second `shift_up` pulse during SHIFT is ignored.
- Gear 2:
  - `shift_down` at `rpm`=7000 is rejected (10500>9000): `gear` stays 2 and `shifting` stays 0.
  - `shift_down` at `rpm`=4000 is accepted: `gear`=1, `rpm`=6000.
  - Simultaneous up and down edges: no change.
- `reset_status` asserted at tick 5 of a SHIFT from gear 2 to 3: next tick `gear`=0, `rpm`=1000, `shifting`=0, state STAGED. A `race_go` edge then returns to RUN.
